// File: rtl/stream_mux_n1.sv
// stream_mux_n1: NCH-to-1 registered valid/ready stream mux that drains its output before switching.
// Define STREAM_MUX_SKID_EN to add a one-word skid slot so IN_READY comes from registered state only.
//
// state | meaning
// RUN   | forwarding channel sel_q; accepts when the output stage has space
// DRAIN | input stalled; once output (and skid) are empty, sel_q <= tgt_q
module stream_mux_n1 #(
    parameter int WIDTH = 4,
    parameter int NCH   = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic [NCH*WIDTH-1:0]   IN_DATA,
    input  logic [NCH-1:0]         IN_VALID,
    output logic [NCH-1:0]         IN_READY,
    input  logic [$clog2(NCH)-1:0] CTRL,
    output logic [WIDTH-1:0]       OUT1,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [$clog2(NCH)-1:0] SEL_ACTIVE,
    output logic                   SWITCHING
);
    localparam int SELW = $clog2(NCH);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [SELW-1:0]  tgt_q, tgt_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic             out_valid_q, out_valid_d;

    logic             ctrl_in_range;
    logic             change_req;
    logic             accept_ok;
    logic             stage_empty;
    logic             xfer_in;
    logic [WIDTH-1:0] sel_data;
    logic             sel_valid;

`ifdef STREAM_MUX_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
`endif

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (sel_q == SELW'(i)) begin
                sel_data  = IN_DATA[i*WIDTH +: WIDTH];
                sel_valid = IN_VALID[i];
            end
        end
    end

    // Out-of-range requests are treated as "keep the current channel".
    assign ctrl_in_range = (int'(CTRL) < NCH);
    assign change_req    = ctrl_in_range && (CTRL != sel_q);

`ifdef STREAM_MUX_SKID_EN
    assign accept_ok   = (state_q == RUN) && !skid_valid_q;
    assign stage_empty = !out_valid_q && !skid_valid_q;
`else
    assign accept_ok   = (state_q == RUN) && !change_req && (!out_valid_q || OUT_READY);
    assign stage_empty = !out_valid_q;
`endif

    assign xfer_in = sel_valid && accept_ok;

    always_comb begin
        IN_READY = '0;
        if (RST_N && accept_ok) begin
            for (int i = 0; i < NCH; i++) begin
                IN_READY[i] = (sel_q == SELW'(i));
            end
        end
    end

    always_comb begin
        out1_d      = out1_q;
        out_valid_d = out_valid_q;
`ifdef STREAM_MUX_SKID_EN
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || OUT_READY) begin
            // Older word in the skid slot always goes out before any new input.
            if (skid_valid_q) begin
                out1_d       = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (xfer_in) begin
                out1_d      = sel_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (xfer_in) begin
            skid_data_d  = sel_data;
            skid_valid_d = 1'b1;
        end
`else
        if (xfer_in) begin
            out1_d      = sel_data;
            out_valid_d = 1'b1;
        end else if (out_valid_q && OUT_READY) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        case (state_q)
            RUN: begin
                if (change_req) begin
                    state_d = DRAIN;
                    tgt_d   = CTRL;
                end
            end
            DRAIN: begin
                if (ctrl_in_range) begin
                    tgt_d = CTRL;
                end
                if (stage_empty) begin
                    state_d = RUN;
                    sel_d   = tgt_q;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= RUN;
            sel_q        <= '0;
            tgt_q        <= '0;
            out1_q       <= '0;
            out_valid_q  <= 1'b0;
`ifdef STREAM_MUX_SKID_EN
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            tgt_q        <= tgt_d;
            out1_q       <= out1_d;
            out_valid_q  <= out_valid_d;
`ifdef STREAM_MUX_SKID_EN
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
`endif
        end
    end

    assign OUT1       = out1_q;
    assign OUT_VALID  = out_valid_q;
    assign SEL_ACTIVE = sel_q;
    assign SWITCHING  = (state_q == DRAIN);

endmodule
